brc_iter: RTL and testbench

BRC_ITER -- requirements
Module: brc_iter

---
 rtl/brc_iter.sv | 143 ++++++++++++++
 tb/tb_brc_iter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/brc_iter.sv
// brc_iter: iterative branch comparator.
// The operands are compared one slice per cycle, starting with the most
// significant slice. The compare stops at the first slice that differs.
// For a signed compare, the operand MSBs are inverted when the request is
// captured. After that, every slice compare is unsigned.
module brc_iter #(
  parameter int DATA_WIDTH  = 32,
  parameter int SLICE_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_rs1_data,
  input  logic [DATA_WIDTH-1:0] i_rs2_data,
  input  logic                  i_br_un,
  input  logic [2:0]            i_funct3,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_br_less,
  output logic                  o_br_equal,
  output logic                  o_br_taken,
  output logic                  o_br_illegal
);

  localparam int NSLICE = DATA_WIDTH / SLICE_WIDTH;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t                r_state;
  logic [IDXW-1:0]       r_idx;
  logic [DATA_WIDTH-1:0] r_rs1, r_rs2;
  logic [2:0]            r_funct3;
  logic                  r_ready, r_valid;
  logic                  r_less, r_equal, r_taken, r_illegal;

  // Signedness only matters at capture (the MSB flip), so br_un is not kept
  // once the request has been accepted.
  logic [DATA_WIDTH-1:0] w_msb_flip;
  assign w_msb_flip = {~i_br_un, {(DATA_WIDTH-1){1'b0}}};

  // The operands shift left by one slice per cycle, so the slice being
  // examined always sits at the top of the register.
  logic [SLICE_WIDTH-1:0] w_s1, w_s2;
  assign w_s1 = r_rs1[DATA_WIDTH-1 -: SLICE_WIDTH];
  assign w_s2 = r_rs2[DATA_WIDTH-1 -: SLICE_WIDTH];

  logic w_slice_eq, w_done, w_less_nx, w_equal_nx, w_taken_nx, w_illegal_nx;
  assign w_slice_eq   = (w_s1 == w_s2);
  assign w_done       = !w_slice_eq || (r_idx == '0);
  assign w_less_nx    = !w_slice_eq && (w_s1 < w_s2);
  assign w_equal_nx   = w_slice_eq;
  assign w_illegal_nx = (r_funct3[2:1] == 2'b01);

  // Branch decision from the flags that are about to be registered.
  always_comb begin
    w_taken_nx = 1'b0;
    case (r_funct3)
      3'b000:          w_taken_nx = w_equal_nx;
      3'b001:          w_taken_nx = !w_equal_nx;
      3'b100, 3'b110:  w_taken_nx = w_less_nx;
      3'b101, 3'b111:  w_taken_nx = !w_less_nx;
      default:         w_taken_nx = 1'b0;
    endcase
  end

  // Control FSM with registered handshake and result outputs.
  // A flush takes priority over both accept and result handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_idx     <= IDX_TOP;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_funct3  <= '0;
      r_ready   <= 1'b1;
      r_valid   <= 1'b0;
      r_less    <= 1'b0;
      r_equal   <= 1'b0;
      r_taken   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (i_flush) begin
      r_state   <= IDLE;
      r_idx     <= IDX_TOP;
      r_ready   <= 1'b1;
      r_valid   <= 1'b0;
      r_less    <= 1'b0;
      r_equal   <= 1'b0;
      r_taken   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_rs1    <= i_rs1_data ^ w_msb_flip;
            r_rs2    <= i_rs2_data ^ w_msb_flip;
            r_funct3 <= i_funct3;
            r_idx    <= IDX_TOP;
            r_ready  <= 1'b0;
            r_state  <= CMP;
          end
        end
        CMP: begin
          if (w_done) begin
            r_less    <= w_less_nx;
            r_equal   <= w_equal_nx;
            r_taken   <= w_taken_nx;
            r_illegal <= w_illegal_nx;
            r_valid   <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_idx <= r_idx - IDXW'(1);
            r_rs1 <= r_rs1 << SLICE_WIDTH;
            r_rs2 <= r_rs2 << SLICE_WIDTH;
          end
        end
        DONE: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready      = r_ready;
  assign o_valid      = r_valid;
  assign o_br_less    = r_less;
  assign o_br_equal   = r_equal;
  assign o_br_taken   = r_taken;
  assign o_br_illegal = r_illegal;

endmodule

// File: tb/tb_brc_iter.sv
// tb_brc_iter: directed and random checks of brc_iter against an arithmetic model.
module tb_brc_iter;

  localparam int DW  = 32;
  localparam int SW  = 8;
  localparam int NSL = DW / SW;

  logic          clk, rst_n, flush, ivalid, oready, ovalid, iready;
  logic [DW-1:0] rs1, rs2;
  logic          br_un;
  logic [2:0]    funct3;
  logic          less, equal, taken, illegal;

  int n_chk = 0;
  int n_err = 0;

  brc_iter #(.DATA_WIDTH(DW), .SLICE_WIDTH(SW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(ivalid),
    .o_ready(oready), .i_rs1_data(rs1), .i_rs2_data(rs2), .i_br_un(br_un),
    .i_funct3(funct3), .o_valid(ovalid), .i_ready(iready),
    .o_br_less(less), .o_br_equal(equal), .o_br_taken(taken),
    .o_br_illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: full-width arithmetic compare; m = position of first differing byte from the top.
  task automatic model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic un,
                       input logic [2:0] f3, output logic lt, output logic eq,
                       output logic tk, output logic il, output int m);
    bit found;
    lt = un ? (a < b) : ($signed(a) < $signed(b));
    eq = (a == b);
    il = (f3 == 3'b010) || (f3 == 3'b011);
    case (f3)
      3'b000:         tk = eq;
      3'b001:         tk = !eq;
      3'b100, 3'b110: tk = lt;
      3'b101, 3'b111: tk = !lt;
      default:        tk = 1'b0;
    endcase
    m = NSL;
    found = 0;
    for (int k = NSL - 1; k >= 0; k--) begin
      if (!found && (((a >> (SW * k)) & 32'hFF) != ((b >> (SW * k)) & 32'hFF))) begin
        m = NSL - k;
        found = 1;
      end
    end
  endtask

  task automatic run_req(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic un,
                         input logic [2:0] f3, input int hold);
    logic lt, eq, tk, il;
    int   m, cyc;
    model(a, b, un, f3, lt, eq, tk, il, m);
    @(negedge clk);
    chk("ready_idle", {31'b0, oready}, 32'd1);
    rs1 = a; rs2 = b; br_un = un; funct3 = f3; ivalid = 1'b1;
    @(posedge clk); #1;
    ivalid = 1'b0;
    cyc = 0;
    while (!ovalid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", cyc, m);
    chk("less", {31'b0, less}, {31'b0, lt});
    chk("equal", {31'b0, equal}, {31'b0, eq});
    chk("taken", {31'b0, taken}, {31'b0, tk});
    chk("illegal", {31'b0, illegal}, {31'b0, il});
    // Consumer stalls while a new request is offered: result must hold.
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      ivalid = 1'b1; rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, ovalid}, 32'd1);
      chk("hold_ready", {31'b0, oready}, 32'd0);
      chk("hold_flags", {28'b0, less, equal, taken, illegal}, {28'b0, lt, eq, tk, il});
    end
    @(negedge clk);
    ivalid = 1'b0; iready = 1'b1;
    @(posedge clk); #1;
    iready = 1'b0;
    chk("hs_valid", {31'b0, ovalid}, 32'd0);
    chk("hs_ready", {31'b0, oready}, 32'd1);
  endtask

  // Operand pair generator biased toward early-exit and full-length compares.
  task automatic gen(output logic [DW-1:0] a, output logic [DW-1:0] b);
    int mode;
    logic [DW-1:0] mask;
    mode = $urandom_range(0, 2);
    a = $urandom;
    b = $urandom;
    if (mode == 1) b = a;
    if (mode == 2) begin
      mask = 32'hFF << (SW * $urandom_range(0, NSL - 1));
      b = (a & ~mask) | (b & mask);
    end
  endtask

  task automatic no_valid_for(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk(tag, {31'b0, ovalid}, 32'd0);
    end
  endtask

  initial begin
    logic [DW-1:0] a, b;
    rst_n = 1'b0; flush = 1'b0; ivalid = 1'b0; iready = 1'b0;
    rs1 = '0; rs2 = '0; br_un = 1'b0; funct3 = '0;
    #1;
    chk("rst_valid", {31'b0, ovalid}, 32'd0);
    chk("rst_flags", {28'b0, less, equal, taken, illegal}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rst_ready", {31'b0, oready}, 32'd1);

    run_req(32'hFFFFFFFF, 32'h00000001, 1'b0, 3'b100, 0);
    run_req(32'hFFFFFFFF, 32'h00000001, 1'b1, 3'b110, 0);
    run_req(32'h12345678, 32'h12345678, 1'b0, 3'b000, 0);
    run_req(32'h12345678, 32'h12345678, 1'b0, 3'b001, 0);
    run_req(32'h12345600, 32'h12345601, 1'b1, 3'b111, 0);
    run_req(32'h12345600, 32'h12345601, 1'b1, 3'b011, 0);
    run_req(32'h80000000, 32'h7FFFFFFF, 1'b0, 3'b101, 3);

    // Flush during CMP drops the request and clears flags left by the previous result.
    @(negedge clk);
    rs1 = 32'h12345678; rs2 = 32'h12345678; funct3 = 3'b000; br_un = 1'b0; ivalid = 1'b1;
    @(posedge clk); #1 ivalid = 1'b0;
    @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_ready", {31'b0, oready}, 32'd1);
    chk("flush_flags", {28'b0, less, equal, taken, illegal}, 32'd0);
    no_valid_for(6, "flush_novalid");
    run_req(32'h12345678, 32'h12345678, 1'b0, 3'b000, 0);

    // Asynchronous reset mid-compare.
    @(negedge clk);
    rs1 = 32'h12345678; rs2 = 32'h12345678; funct3 = 3'b000; ivalid = 1'b1;
    @(posedge clk); #1 ivalid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", {31'b0, oready}, 32'd1);
    chk("arst_flags", {29'b0, ovalid, equal, taken}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    no_valid_for(6, "arst_novalid");
    run_req(32'h12345678, 32'h12345678, 1'b0, 3'b000, 0);

    // Flush wins over a simultaneous accept.
    @(negedge clk); ivalid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 ivalid = 1'b0; flush = 1'b0;
    chk("flush_vs_accept", {31'b0, oready}, 32'd1);
    no_valid_for(5, "flush_vs_accept_nv");

    for (int t = 0; t < 40; t++) begin
      gen(a, b);
      run_req(a, b, 1'($urandom), 3'($urandom), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
